hit_scorer: RTL and testbench

//  Converts per-mole hit/miss pulses into a per-hit points value for score_counter.

---
 rtl/whac_pkg.sv | 27 ++
 rtl/hit_scorer_cycle_timer.sv | 31 +++
 rtl/hit_scorer.sv | 157 +++++++++++++++
 tb/tb_hit_scorer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/whac_pkg.sv
// Shared types and constants for the whack-a-mole scoring path.
package whac_pkg;

   // Width of the per-hit points bus feeding score_counter.
   localparam int SCORE_INC_W  = 7;
   // Largest points value a single hit may award.
   localparam int MAX_INCREASE = 99;
   // Width of the multiplier output.
   localparam int MULT_W       = 4;
   // Width of the full-precision points product.
   localparam int PROD_W       = SCORE_INC_W + MULT_W;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      LOCKOUT = 2'd2
   } hit_state_t;

   // Clamp a full-width points product to the largest single-hit award.
   function automatic logic [SCORE_INC_W-1:0] sat_score(input logic [PROD_W-1:0] product);
      if (product > PROD_W'(MAX_INCREASE)) begin
         return SCORE_INC_W'(MAX_INCREASE);
      end
      return product[SCORE_INC_W-1:0];
   endfunction

endpackage

// File: rtl/hit_scorer_cycle_timer.sv
// Loadable down-counter with a done flag. The count holds at zero until the
// next load; clear has priority over load.
module cycle_timer #(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count_reg;

   // Count down towards zero after each load; clear or reset parks it at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/hit_scorer.sv
// Turns hit/miss pulses into a per-hit points value for score_counter, with a
// combo streak that raises the multiplier, a streak timeout, and a miss lockout.
module hit_scorer
   import whac_pkg::*;
#(
   parameter int BASE_POINTS   = 5,
   parameter int COMBO_STEP    = 4,
   parameter int MAX_MULT      = 8,
   parameter int MAX_COMBO     = 63,
   parameter int COMBO_TIMEOUT = 2000,
   parameter int MISS_LOCK     = 500
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                game_active,
   input  logic                                hit_pulse,
   input  logic                                miss_pulse,
   output logic [SCORE_INC_W-1:0]              score_increase,
   output logic [$clog2(MAX_COMBO+1)-1:0]      combo_count,
   output logic [MULT_W-1:0]                   multiplier,
   output logic                                locked
);

   localparam int COMBO_W   = $clog2(MAX_COMBO + 1);
   localparam int TIMEOUT_W = $clog2(COMBO_TIMEOUT + 1);
   localparam int LOCK_W    = $clog2(MISS_LOCK + 1);

   // Timers are loaded with N-1 so that the state change lands exactly N
   // cycles after the loading event (the done cycle itself counts as one).
   localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(COMBO_TIMEOUT - 1);
   localparam logic [LOCK_W-1:0]    LOCK_LOAD    = LOCK_W'(MISS_LOCK - 1);
   localparam logic [PROD_W-1:0]    BASE_WIDE    = PROD_W'(BASE_POINTS);

   hit_state_t                 state_reg;
   logic [COMBO_W-1:0]         combo_reg;
   logic [COMBO_W-1:0]         combo_next;
   logic [MULT_W-1:0]          mult_reg;
   logic [MULT_W-1:0]          mult_next;
   logic [SCORE_INC_W-1:0]     score_reg;
   logic                       locked_reg;

   logic                       hit_ok;
   logic                       miss_ok;
   logic                       combo_timeout;
   logic                       timeout_done;
   logic                       lock_done;
   logic                       timeout_clear;
   logic                       lock_clear;
   logic [PROD_W-1:0]          product;
   int                         mult_calc;

   // Qualify the input pulses: a miss wins over a simultaneous hit, and hits
   // are ignored while locked out or outside a round.
   always_comb begin
      miss_ok       = game_active && miss_pulse;
      hit_ok        = game_active && hit_pulse && !miss_pulse && (state_reg != LOCKOUT);
      combo_timeout = game_active && (state_reg == ACTIVE) && timeout_done && !hit_ok && !miss_ok;
      timeout_clear = !game_active || miss_ok;
      lock_clear    = !game_active;
   end

   // Next streak length: cleared by a miss, a timeout or the end of a round,
   // otherwise bumped by each accepted hit up to its ceiling.
   always_comb begin
      combo_next = combo_reg;
      if (!game_active || miss_ok || combo_timeout) begin
         combo_next = '0;
      end else if (hit_ok) begin
         if (combo_reg != COMBO_W'(MAX_COMBO)) begin
            combo_next = combo_reg + 1'b1;
         end
      end
   end

   // Multiplier follows the streak: one step per COMBO_STEP hits, capped.
   always_comb begin
      mult_calc = int'(combo_next) / COMBO_STEP + 1;
      if (mult_calc > MAX_MULT) begin
         mult_calc = MAX_MULT;
      end
      mult_next = MULT_W'(mult_calc);
   end

   // Points use the multiplier in force before the hit, at full product width.
   assign product = BASE_WIDE * PROD_W'(mult_reg);

   cycle_timer #(
      .WIDTH      (TIMEOUT_W)
   ) u_combo_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      (timeout_clear),
      .load       (hit_ok),
      .load_value (TIMEOUT_LOAD),
      .done       (timeout_done)
   );

   cycle_timer #(
      .WIDTH      (LOCK_W)
   ) u_lock_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      (lock_clear),
      .load       (miss_ok),
      .load_value (LOCK_LOAD),
      .done       (lock_done)
   );

   // Scoring FSM with registered outputs; score_reg is a one-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         combo_reg  <= '0;
         mult_reg   <= MULT_W'(1);
         score_reg  <= '0;
         locked_reg <= 1'b0;
      end else begin
         score_reg <= '0;
         combo_reg <= combo_next;
         mult_reg  <= mult_next;
         if (!game_active) begin
            state_reg  <= IDLE;
            locked_reg <= 1'b0;
         end else if (miss_ok) begin
            state_reg  <= LOCKOUT;
            locked_reg <= 1'b1;
         end else begin
            case (state_reg)
               IDLE, ACTIVE: begin
                  if (hit_ok) begin
                     score_reg <= sat_score(product);
                     state_reg <= ACTIVE;
                  end else if (combo_timeout) begin
                     state_reg <= IDLE;
                  end
               end
               LOCKOUT: begin
                  if (lock_done) begin
                     state_reg  <= IDLE;
                     locked_reg <= 1'b0;
                  end
               end
               default: begin
                  state_reg  <= IDLE;
                  locked_reg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign score_increase = score_reg;
   assign combo_count    = combo_reg;
   assign multiplier     = mult_reg;
   assign locked         = locked_reg;

endmodule

// File: tb/tb_hit_scorer.sv
// Randomized and directed checks of hit_scorer against a cycle-level model.
// Two instances share the inputs: default points and 20 points per hit.
module tb_hit_scorer;

   logic       clk = 1'b0;
   logic       rst;
   logic       game_active;
   logic       hit_pulse;
   logic       miss_pulse;
   logic [6:0] score_a, score_b;
   logic [5:0] combo_a, combo_b;
   logic [3:0] mult_a, mult_b;
   logic       locked_a, locked_b;

   always #5 clk = ~clk;

   hit_scorer dut_a (
      .clk            (clk),
      .rst            (rst),
      .game_active    (game_active),
      .hit_pulse      (hit_pulse),
      .miss_pulse     (miss_pulse),
      .score_increase (score_a),
      .combo_count    (combo_a),
      .multiplier     (mult_a),
      .locked         (locked_a)
   );

   hit_scorer #(.BASE_POINTS(20)) dut_b (
      .clk            (clk),
      .rst            (rst),
      .game_active    (game_active),
      .hit_pulse      (hit_pulse),
      .miss_pulse     (miss_pulse),
      .score_increase (score_b),
      .combo_count    (combo_b),
      .multiplier     (mult_b),
      .locked         (locked_b)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
      checks++;
      if (obs !== 32'(exp)) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: streak length, remaining lockout and inactivity cycles.
   int m_combo, m_lock_rem, m_idle_rem, m_score5, m_score20;
   bit m_locked;

   function automatic int mult_of(input int c);
      int m;
      m = 1 + c / 4;
      return (m > 8) ? 8 : m;
   endfunction

   function automatic int cap99(input int v);
      return (v > 99) ? 99 : v;
   endfunction

   task automatic model_reset();
      m_combo = 0; m_lock_rem = 0; m_idle_rem = 0;
      m_score5 = 0; m_score20 = 0; m_locked = 0;
   endtask

   task automatic model_step(input bit h, input bit m, input bit ga);
      m_score5  = 0;
      m_score20 = 0;
      if (!ga) begin
         m_combo = 0; m_locked = 0; m_lock_rem = 0; m_idle_rem = 0;
      end else if (m) begin
         m_combo = 0; m_locked = 1; m_lock_rem = 500; m_idle_rem = 0;
      end else if (m_locked) begin
         m_lock_rem--;
         if (m_lock_rem == 0) m_locked = 0;
      end else if (h) begin
         m_score5   = cap99(5 * mult_of(m_combo));
         m_score20  = cap99(20 * mult_of(m_combo));
         m_combo    = (m_combo < 63) ? m_combo + 1 : 63;
         m_idle_rem = 2000;
      end else if (m_idle_rem > 0) begin
         m_idle_rem--;
         if (m_idle_rem == 0) m_combo = 0;
      end
   endtask

   task automatic check_outputs();
      check_val("score_a",  score_a,  m_score5);
      check_val("score_b",  score_b,  m_score20);
      check_val("combo_a",  combo_a,  m_combo);
      check_val("combo_b",  combo_b,  m_combo);
      check_val("mult_a",   mult_a,   mult_of(m_combo));
      check_val("locked_a", locked_a, int'(m_locked));
   endtask

   // One clock cycle with the given inputs, then compare against the model.
   task automatic tick(input bit h, input bit m, input bit ga);
      hit_pulse   = h;
      miss_pulse  = m;
      game_active = ga;
      @(posedge clk);
      model_step(h, m, ga);
      #1;
      check_outputs();
      if (h || m)
         $display("txn t=%0t hit=%0b miss=%0b ga=%0b score=%0d/%0d combo=%0d mult=%0d locked=%0b",
                  $time, h, m, ga, score_a, score_b, combo_a, mult_a, locked_a);
   endtask

   task automatic do_reset();
      rst = 1'b1; hit_pulse = 1'b0; miss_pulse = 1'b0; game_active = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      check_outputs();
   endtask

   initial begin
      rst = 1'b1; hit_pulse = 1'b0; miss_pulse = 1'b0; game_active = 1'b0;

      // 1: reset then idle
      do_reset();
      repeat (5) tick(0, 0, 1);
      check_val("t1_score", score_a, 0);
      check_val("t1_combo", combo_a, 0);
      check_val("t1_mult", mult_a, 1);
      check_val("t1_locked", locked_a, 0);

      // 2: five hits three cycles apart -> 5,5,5,5,10
      begin
         int exp_pulse [5] = '{5, 5, 5, 5, 10};
         for (int i = 0; i < 5; i++) begin
            tick(1, 0, 1);
            check_val("t2_pulse", score_a, exp_pulse[i]);
            tick(0, 0, 1);
            check_val("t2_pulse_clear", score_a, 0);
            tick(0, 0, 1);
         end
      end
      check_val("t2_combo", combo_a, 5);
      check_val("t2_mult", mult_a, 2);

      // 3: 36 back-to-back hits at 20 points -> multiplier 8, award capped at 99
      do_reset();
      for (int i = 0; i < 36; i++) tick(1, 0, 1);
      check_val("t3_score_sat", score_b, 99);
      check_val("t3_mult_sat", mult_b, 8);
      for (int i = 0; i < 30; i++) tick(1, 0, 1);
      check_val("t3_combo_sat", combo_a, 63);
      tick(0, 0, 1);

      // 4: three hits, miss, ignored hit at +250, scoring hit at +501
      do_reset();
      for (int i = 0; i < 3; i++) tick(1, 0, 1);
      tick(0, 1, 1);
      check_val("t4_combo", combo_a, 0);
      check_val("t4_locked", locked_a, 1);
      for (int i = 1; i < 250; i++) tick(0, 0, 1);
      tick(1, 0, 1);
      check_val("t4_ignored", score_a, 0);
      check_val("t4_ignored_combo", combo_a, 0);
      for (int i = 251; i <= 500; i++) tick(0, 0, 1);
      check_val("t4_unlocked", locked_a, 0);
      tick(1, 0, 1);
      check_val("t4_score", score_a, 5);

      // 5: hit, 2000 idle cycles clear the streak, hit at 2001 scores 5
      do_reset();
      tick(1, 0, 1);
      for (int i = 1; i < 2000; i++) tick(0, 0, 1);
      check_val("t5_combo_before", combo_a, 1);
      tick(0, 0, 1);
      check_val("t5_combo_timeout", combo_a, 0);
      tick(1, 0, 1);
      check_val("t5_score", score_a, 5);
      check_val("t5_combo_after", combo_a, 1);

      // 6: simultaneous hit and miss is a miss
      tick(1, 1, 1);
      check_val("t6_score", score_a, 0);
      check_val("t6_locked", locked_a, 1);

      // 7: async reset mid-lockout, then a hit scores 5
      for (int i = 0; i < 10; i++) tick(0, 0, 1);
      #2 rst = 1'b1;
      #1;
      check_val("t7_score", score_a, 0);
      check_val("t7_combo", combo_a, 0);
      check_val("t7_mult", mult_a, 1);
      check_val("t7_locked", locked_a, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      tick(1, 0, 1);
      check_val("t7_score_after", score_a, 5);

      // 8: randomized traffic including round stops
      for (int i = 0; i < 4000; i++) begin
         bit h, m, ga;
         h  = ($urandom_range(0, 3) == 0);
         m  = ($urandom_range(0, 149) == 0);
         ga = ($urandom_range(0, 299) != 0);
         tick(h, m, ga);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
